usb_out_ep_rx: RTL and testbench

USB_OUT_EP_RX -- requirements
Module: usb_out_ep_rx

---
 rtl/usb_out_ep_rx_if.sv | 26 ++
 rtl/usb_out_ep_rx.sv | 157 +++++++++++++++
 tb/tb_usb_out_ep_rx.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_out_ep_rx_if.sv
// Signal bundle between the USB controller, the OUT endpoint receiver and the
// downstream byte-stream consumer.
interface usb_out_ep_rx_if;
  logic [3:0]  usb_endpt;
  logic        usb_rxact;
  logic        usb_rxval;
  logic [7:0]  usb_rxdata;
  logic        usb_rxpktval;
  logic        usb_rxrdy;
  logic        out_tvalid;
  logic        out_tready;
  logic [7:0]  out_tdata;
  logic        out_tlast;
  logic [11:0] out_tlen;
  logic [7:0]  drop_cnt;

  modport slave (
    input  usb_endpt, usb_rxact, usb_rxval, usb_rxdata, usb_rxpktval, out_tready,
    output usb_rxrdy, out_tvalid, out_tdata, out_tlast, out_tlen, drop_cnt
  );

  modport master (
    output usb_endpt, usb_rxact, usb_rxval, usb_rxdata, usb_rxpktval, out_tready,
    input  usb_rxrdy, out_tvalid, out_tdata, out_tlast, out_tlen, drop_cnt
  );
endinterface

// File: rtl/usb_out_ep_rx.sv
// USB OUT endpoint receiver: buffers packet bytes speculatively, commits good
// packets (length FIFO entry) or rolls them back, and streams committed bytes.
module usb_out_ep_rx #(
  parameter logic [3:0] ENDPT          = 4'd2,
  parameter int         MAX_PKT        = 512,
  parameter int         DEPTH_LOG2     = 11,
  parameter int         LEN_DEPTH_LOG2 = 3
) (
  input  logic hclk,
  input  logic reset,
  usb_out_ep_rx_if.slave bus
);
  localparam int AW     = DEPTH_LOG2;
  localparam int LW     = LEN_DEPTH_LOG2;
  localparam int DEPTH  = 1 << AW;
  localparam int LDEPTH = 1 << LW;

  typedef enum logic [1:0] {IDLE, RECV, END} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] cm_ptr_q, cm_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [11:0] cnt_q, cnt_d;
  logic        pktval_q, pktval_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  drop_q, drop_d;
  logic        rxrdy_q, rxrdy_d;
  logic [LW:0] lf_wr_q, lf_wr_d;
  logic [LW:0] lf_rd_q, lf_rd_d;
  logic [11:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]  rdata_q;

  logic [7:0]  buf_mem [DEPTH];
  logic [11:0] len_mem [LDEPTH];

  logic        wr_en;
  logic        lf_push;
  logic        lf_pop;
  logic        xfer;
  logic        lf_empty;
  logic        lf_full_d;
  logic        tlast_c;
  logic [11:0] head_len;
  logic [AW:0] used_d;

  // Receive side: speculative writes beyond cm_ptr until the packet is judged.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    cnt_d    = cnt_q;
    pktval_d = pktval_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    wr_en    = 1'b0;
    lf_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.usb_rxact && (bus.usb_endpt == ENDPT) && rxrdy_q) begin
          state_d  = RECV;
          cnt_d    = 12'd0;
          pktval_d = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      RECV: begin
        if (bus.usb_rxval) begin
          if (cnt_q == 12'(MAX_PKT)) begin
            ovf_d = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            cnt_d    = cnt_q + 12'd1;
          end
        end
        if (bus.usb_rxpktval) pktval_d = 1'b1;
        if (!bus.usb_rxact) state_d = END;
      end
      END: begin
        state_d = IDLE;
        if (pktval_q && !ovf_q && (cnt_q != 12'd0)) begin
          cm_ptr_d = wr_ptr_q;
          lf_push  = 1'b1;
        end else if (!pktval_q || ovf_q) begin
          wr_ptr_d = cm_ptr_q;
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read side: only committed packets are visible through the length FIFO.
  always_comb begin
    lf_empty = (lf_wr_q == lf_rd_q);
    head_len = len_mem[lf_rd_q[LW-1:0]];
    tlast_c  = (rd_cnt_q == head_len - 12'd1);
    xfer     = !lf_empty && bus.out_tready;
    lf_pop   = xfer && tlast_c;
    rd_ptr_d = xfer ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    rd_cnt_d = lf_pop ? 12'd0 : (xfer ? rd_cnt_q + 12'd1 : rd_cnt_q);
    lf_wr_d  = lf_push ? lf_wr_q + (LW+1)'(1) : lf_wr_q;
    lf_rd_d  = lf_pop ? lf_rd_q + (LW+1)'(1) : lf_rd_q;
    lf_full_d = (lf_wr_d[LW] != lf_rd_d[LW]) && (lf_wr_d[LW-1:0] == lf_rd_d[LW-1:0]);
    used_d   = wr_ptr_d - rd_ptr_d;
    rxrdy_d  = (state_d == IDLE) && ((DEPTH - int'(used_d)) >= MAX_PKT) && !lf_full_d;
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pktval_q <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      rxrdy_q  <= 1'b0;
      lf_wr_q  <= '0;
      lf_rd_q  <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pktval_q <= pktval_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      rxrdy_q  <= rxrdy_d;
      lf_wr_q  <= lf_wr_d;
      lf_rd_q  <= lf_rd_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (wr_en) buf_mem[wr_ptr_q[AW-1:0]] <= bus.usb_rxdata;
    if (lf_push) len_mem[lf_wr_q[LW-1:0]] <= cnt_q;
  end

  // Prefetch from the next read address so rdata_q always holds byte rd_ptr_q.
  always_ff @(posedge hclk) begin
    if (reset) rdata_q <= 8'd0;
    else       rdata_q <= buf_mem[rd_ptr_d[AW-1:0]];
  end

  assign bus.usb_rxrdy  = rxrdy_q;
  assign bus.drop_cnt   = drop_q;
  assign bus.out_tvalid = !lf_empty;
  assign bus.out_tdata  = lf_empty ? 8'd0 : rdata_q;
  assign bus.out_tlast  = !lf_empty && tlast_c;
  assign bus.out_tlen   = lf_empty ? 12'd0 : head_len;
endmodule

// File: tb/tb_usb_out_ep_rx.sv
// Bench for usb_out_ep_rx: packet table plus hand sequences, with a byte
// scoreboard filled as packets are sent and drained by the output monitor.
module tb_usb_out_ep_rx;
  logic hclk  = 1'b0;
  logic reset = 1'b1;
  always #5 hclk = ~hclk;

  usb_out_ep_rx_if bus();

  usb_out_ep_rx #(
    .ENDPT(4'd2), .MAX_PKT(512), .DEPTH_LOG2(11), .LEN_DEPTH_LOG2(3)
  ) dut (
    .hclk(hclk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [11:0] len;
  } exp_t;

  typedef struct {
    logic [3:0] ep;
    int         len;
    bit         pv;
    logic [7:0] seed;
    bit         outp;
    int         drop_exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   n_vec = 0;
  int   n_miss = 0;
  int   tready_mode = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // tready driver: 0 = low, 1 = high, otherwise random with 75% duty
  initial begin
    bus.out_tready = 1'b0;
    forever begin
      @(posedge hclk);
      #1;
      case (tready_mode)
        0:       bus.out_tready = 1'b0;
        1:       bus.out_tready = 1'b1;
        default: bus.out_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor: compare each handshake against the scoreboard and
  // check that a stalled beat is held unchanged.
  initial begin
    logic [7:0]  hd;
    logic        hl;
    logic [11:0] hn;
    bit          hold;
    exp_t        e;
    hold = 1'b0;
    hd = '0; hl = 1'b0; hn = '0;
    forever begin
      @(negedge hclk);
      if (hold && !reset)
        chk("hold_beat", {10'd0, bus.out_tvalid, bus.out_tlast, bus.out_tlen, bus.out_tdata},
            {10'd0, 1'b1, hl, hn, hd});
      hold = 1'b0;
      if (!reset && bus.out_tvalid) begin
        if (bus.out_tready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_byte: got %02h with nothing expected", bus.out_tdata);
          end else begin
            e = sb.pop_front();
            $display("beat data=%02h last=%0d len=%0d", bus.out_tdata, bus.out_tlast, bus.out_tlen);
            chk("beat{last,len,data}", {11'd0, bus.out_tlast, bus.out_tlen, bus.out_tdata},
                {11'd0, e.last, e.len, e.data});
          end
        end else begin
          hold = 1'b1;
          hd = bus.out_tdata;
          hl = bus.out_tlast;
          hn = bus.out_tlen;
        end
      end
    end
  end

  task automatic wait_rdy();
    int k;
    k = 0;
    @(negedge hclk);
    while (!bus.usb_rxrdy && k < 5000) begin
      @(negedge hclk);
      k++;
    end
    if (!bus.usb_rxrdy) chk("rxrdy_timeout", 32'(bus.usb_rxrdy), 32'd1);
  endtask

  // Returns during the cycle after rxact falls (END for an accepted packet).
  task automatic send_pkt(input logic [3:0] ep, input int len, input bit pv,
                          input logic [7:0] seed, input bit outp);
    exp_t e;
    wait_rdy();
    if (outp) begin
      for (int i = 0; i < len; i++) begin
        e.data = seed + 8'(i);
        e.last = (i == len - 1);
        e.len  = 12'(len);
        sb.push_back(e);
      end
    end
    @(posedge hclk); #1;
    bus.usb_endpt = ep;
    bus.usb_rxact = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(posedge hclk); #1;
      bus.usb_rxval  = 1'b1;
      bus.usb_rxdata = seed + 8'(i);
    end
    @(posedge hclk); #1;
    bus.usb_rxval    = 1'b0;
    bus.usb_rxact    = 1'b0;
    bus.usb_rxpktval = pv;
    @(posedge hclk); #1;
    bus.usb_rxpktval = 1'b0;
    $display("pkt ep=%0d len=%0d pktval=%0d seed=%02h", ep, len, pv, seed);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 8000) begin
      @(negedge hclk);
      k++;
    end
    if (sb.size() != 0) chk("drain_timeout_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hs, rdy_at, first, last;
    tbl[0] = '{4'd2,  10, 1'b1, 8'h00, 1'b1, 0};
    tbl[1] = '{4'd2,   8, 1'b0, 8'h30, 1'b0, 1};
    tbl[2] = '{4'd2,   4, 1'b1, 8'h50, 1'b1, 1};
    tbl[3] = '{4'd2, 513, 1'b1, 8'h60, 1'b0, 2};
    tbl[4] = '{4'd3,   6, 1'b1, 8'h70, 1'b0, 2};
    tbl[5] = '{4'd2,   0, 1'b1, 8'h00, 1'b0, 2};
    tbl[6] = '{4'd2, 512, 1'b1, 8'h11, 1'b1, 2};
    tbl[7] = '{4'd2,   1, 1'b1, 8'hEE, 1'b1, 2};
    tbl[8] = '{4'd2,   3, 1'b0, 8'h22, 1'b0, 3};

    bus.usb_endpt = 4'd0;
    bus.usb_rxact = 1'b0;
    bus.usb_rxval = 1'b0;
    bus.usb_rxdata = 8'd0;
    bus.usb_rxpktval = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("reset_rxrdy",  32'(bus.usb_rxrdy),  32'd0);
    chk("reset_tvalid", 32'(bus.out_tvalid), 32'd0);
    chk("reset_tdata",  32'(bus.out_tdata),  32'd0);
    chk("reset_tlast",  32'(bus.out_tlast),  32'd0);
    chk("reset_tlen",   32'(bus.out_tlen),   32'd0);
    chk("reset_drop",   32'(bus.drop_cnt),   32'd0);
    @(posedge hclk); #1;
    reset = 1'b0;
    @(negedge hclk);
    @(negedge hclk);
    chk("rxrdy_second_cycle", 32'(bus.usb_rxrdy), 32'd1);

    for (int k = 0; k < 9; k++) begin
      tready_mode = (k == 0) ? 1 : 2;
      send_pkt(tbl[k].ep, tbl[k].len, tbl[k].pv, tbl[k].seed, tbl[k].outp);
      @(negedge hclk);
      chk("rxrdy_after_pkt", 32'(bus.usb_rxrdy), 32'(tbl[k].ep != 4'd2));
      if (k == 0) begin
        lat = 0;
        while (!bus.out_tvalid && lat < 4) begin
          @(negedge hclk);
          lat++;
        end
        chk("first_byte_latency_le3", 32'(lat <= 3), 32'd1);
      end
      drain();
      repeat (4) @(negedge hclk);
      chk("drop_cnt", 32'(bus.drop_cnt), 32'(tbl[k].drop_exp));
      chk("no_extra_output", 32'(bus.out_tvalid), 32'd0);
    end

    // Fill the buffer with tready low, then stream it all back without bubbles.
    tready_mode = 0;
    send_pkt(4'd2, 512, 1'b1, 8'h10, 1'b1);
    send_pkt(4'd2, 512, 1'b1, 8'h40, 1'b1);
    send_pkt(4'd2, 512, 1'b1, 8'h80, 1'b1);
    send_pkt(4'd2, 512, 1'b1, 8'hC0, 1'b1);
    repeat (3) @(negedge hclk);
    chk("full_rxrdy",  32'(bus.usb_rxrdy),  32'd0);
    chk("full_tvalid", 32'(bus.out_tvalid), 32'd1);
    chk("full_tlen",   32'(bus.out_tlen),   32'd512);
    tready_mode = 1;
    hs = 0; rdy_at = -1; first = -1; last = -1;
    for (int c = 0; c < 3000 && hs < 2048; c++) begin
      @(negedge hclk);
      if (rdy_at < 0 && bus.usb_rxrdy) rdy_at = hs;
      if (bus.out_tvalid && bus.out_tready) begin
        if (first < 0) first = c;
        last = c;
        hs++;
      end
    end
    chk("stream_bytes", 32'(hs), 32'd2048);
    chk("stream_no_bubble", 32'(last - first + 1), 32'd2048);
    chk("rxrdy_after_512", 32'(rdy_at >= 512 && rdy_at <= 513), 32'd1);
    drain();
    repeat (4) @(negedge hclk);
    chk("drop_after_stream", 32'(bus.drop_cnt), 32'd3);

    // Drop counter saturation
    for (int k = 0; k < 251; k++) send_pkt(4'd2, 1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge hclk);
    chk("drop_254", 32'(bus.drop_cnt), 32'd254);
    send_pkt(4'd2, 1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge hclk);
    chk("drop_255", 32'(bus.drop_cnt), 32'd255);
    send_pkt(4'd2, 2, 1'b0, 8'h00, 1'b0);
    send_pkt(4'd2, 1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge hclk);
    chk("drop_saturated", 32'(bus.drop_cnt), 32'd255);

    // Reset in the middle of a packet, then a good 3-byte packet
    wait_rdy();
    @(posedge hclk); #1;
    bus.usb_endpt = 4'd2;
    bus.usb_rxact = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge hclk); #1;
      bus.usb_rxval  = 1'b1;
      bus.usb_rxdata = 8'hF0 + 8'(i);
    end
    @(posedge hclk); #1;
    reset = 1'b1;
    bus.usb_rxval = 1'b0;
    bus.usb_rxact = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    reset = 1'b0;
    @(negedge hclk);
    chk("midreset_drop",   32'(bus.drop_cnt),   32'd0);
    chk("midreset_tvalid", 32'(bus.out_tvalid), 32'd0);
    send_pkt(4'd2, 3, 1'b1, 8'hA0, 1'b1);
    drain();
    repeat (4) @(negedge hclk);
    chk("post_reset_drop",  32'(bus.drop_cnt),   32'd0);
    chk("post_reset_idle",  32'(bus.out_tvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
